// File: rtl/sseg_pkg.sv
// Shared constants and types for the 7-segment scan multiplexer.
package sseg_pkg;

    localparam int MIN_DIGITS = 2;
    localparam int MAX_DIGITS = 8;
    localparam int NIBBLE_W   = 4;

    localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;
    localparam logic                  DP_OFF     = 1'b1;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } slot_state_t;

endpackage

// File: rtl/sseg_scan_tick_gen.sv
// Slot timebase: cycles within a digit slot (cnt) and the digit being scanned (idx).
module scan_tick_gen
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 2000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [$clog2(NUM_DIGITS)-1:0] idx_o,
    output slot_state_t                   slot_state_o,
    output logic                          slot_last_o,
    output logic                          frame_last_o,
    output logic                          frame_first_o
);

    localparam int CNT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_TICKS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        slot_last_o   = (cnt_q == CNT_LAST);
        frame_last_o  = slot_last_o && (idx_q == IDX_LAST);
        frame_first_o = (cnt_q == '0) && (idx_q == '0);
        slot_state_o  = (cnt_q < BLANK_END) ? BLANK : ON;

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_last_o) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed 8-digit common-anode scanner with blanking, leading-zero
// suppression and frame-aligned (tear-free) value updates.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 2000,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]          dp_in,
    input  logic [NUM_DIGITS-1:0]          digit_en,
    input  logic                           load,
    output logic                           load_ack,
    output logic [NIBBLE_W-1:0]            nibble,
    output logic [NUM_DIGITS-1:0]          an,
    output logic                           dp_n,
    output logic                           frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

    if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("sseg_scan_mux: NUM_DIGITS out of range");
    end
    if (DIGIT_TICKS < BLANK_TICKS + 1) begin : g_bad_ticks
        $error("sseg_scan_mux: DIGIT_TICKS must exceed BLANK_TICKS");
    end

    logic [IDX_W-1:0] idx;
    slot_state_t      slot_state;
    logic             slot_last;
    logic             frame_last;
    logic             frame_first;

    scan_tick_gen #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DIGIT_TICKS (DIGIT_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) u_tick (
        .clk           (clk),
        .rst_n         (rst_n),
        .idx_o         (idx),
        .slot_state_o  (slot_state),
        .slot_last_o   (slot_last),
        .frame_last_o  (frame_last),
        .frame_first_o (frame_first)
    );

    logic [VAL_W-1:0]      stg_val_q, stg_val_d, shd_val_q, shd_val_d;
    logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0] stg_en_q, stg_en_d, shd_en_q, shd_en_d;
    logic                  pending_q, pending_d;
    logic [NIBBLE_W-1:0]   nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  dp_n_q, dp_n_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_start_q, frame_start_d;

    logic [NIBBLE_W-1:0]   digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  all_zero;
    logic                  commit;
    logic                  suppressed;
    logic                  lit;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digits
        assign digits[g] = shd_val_q[g*NIBBLE_W +: NIBBLE_W];
    end

    // zero_from[i] is set when every shadow digit from i up to the MSD is zero.
    always_comb begin
        all_zero  = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (digits[i] == '0);
            zero_from[i] = all_zero;
        end
    end

    always_comb begin
        commit    = frame_last && pending_q;

        stg_val_d = stg_val_q;
        stg_dp_d  = stg_dp_q;
        stg_en_d  = stg_en_q;
        pending_d = pending_q;
        shd_val_d = shd_val_q;
        shd_dp_d  = shd_dp_q;
        shd_en_d  = shd_en_q;

        // A load in the commit cycle lands after the commit has taken the old staging.
        if (load) begin
            stg_val_d = value;
            stg_dp_d  = dp_in;
            stg_en_d  = digit_en;
            pending_d = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
        end

        if (commit) begin
            shd_val_d = stg_val_q;
            shd_dp_d  = stg_dp_q;
            shd_en_d  = stg_en_q;
        end

        suppressed = !shd_en_q[idx] ||
                     (LZ_SUPPRESS && (idx != '0) && zero_from[idx]);
        lit        = (slot_state == ON) && !suppressed;

        nibble_d      = digits[idx];
        an_d          = ANODES_OFF[NUM_DIGITS-1:0];
        dp_n_d        = DP_OFF;
        if (lit) begin
            an_d[idx] = 1'b0;
            dp_n_d    = ~shd_dp_q[idx];
        end
        load_ack_d    = commit;
        frame_start_d = frame_first;
    end

    // Enables come out of reset all-on so a freshly reset display shows 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_val_q     <= '0;
            stg_dp_q      <= '0;
            stg_en_q      <= '1;
            pending_q     <= 1'b0;
            shd_val_q     <= '0;
            shd_dp_q      <= '0;
            shd_en_q      <= '1;
            nibble_q      <= '0;
            an_q          <= ANODES_OFF[NUM_DIGITS-1:0];
            dp_n_q        <= DP_OFF;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            stg_val_q     <= stg_val_d;
            stg_dp_q      <= stg_dp_d;
            stg_en_q      <= stg_en_d;
            pending_q     <= pending_d;
            shd_val_q     <= shd_val_d;
            shd_dp_q      <= shd_dp_d;
            shd_en_q      <= shd_en_d;
            nibble_q      <= nibble_d;
            an_q          <= an_d;
            dp_n_q        <= dp_n_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign nibble      = nibble_q;
    assign an          = an_q;
    assign dp_n        = dp_n_q;
    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Scoreboard bench: two scanners (leading-zero suppression on/off) against a frame-level model.
module tb_sseg_scan_mux;

    localparam int N  = 8;
    localparam int T  = 8;
    localparam int BL = 2;
    localparam int F  = N * T;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] value = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  digit_en = '0;
    logic        load = 1'b0;

    logic       ack1, dpn1, fs1, ack0, dpn0, fs0;
    logic [3:0] nib1, nib0;
    logic [7:0] an1, an0;

    sseg_scan_mux #(.NUM_DIGITS(N), .DIGIT_TICKS(T), .BLANK_TICKS(BL), .LZ_SUPPRESS(1'b1)) u_lz1 (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .load(load), .load_ack(ack1), .nibble(nib1), .an(an1), .dp_n(dpn1), .frame_start(fs1)
    );

    sseg_scan_mux #(.NUM_DIGITS(N), .DIGIT_TICKS(T), .BLANK_TICKS(BL), .LZ_SUPPRESS(1'b0)) u_lz0 (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .load(load), .load_ack(ack0), .nibble(nib0), .an(an0), .dp_n(dpn0), .frame_start(fs0)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; equals the scan time of the current cycle.
    int npos;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) npos <= 0;
        else        npos <= npos + 1;
    end

    typedef struct {
        int          frame;
        logic [31:0] v;
        logic [7:0]  dp;
        logic [7:0]  en;
    } load_t;

    load_t       lq[$];
    int          ackq[$];
    logic [31:0] cur_v = '0;
    logic [7:0]  cur_dp = '0;
    logic [7:0]  cur_en = '1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", name, k, act, exp);
        end
    endtask

    function automatic void model(input int k, input bit lz, output logic [7:0] e_an,
                                  output logic e_dpn, output logic [3:0] e_nib);
        int c = k % T;
        int d = (k / T) % N;
        bit lit;
        e_nib = cur_v[4*d +: 4];
        lit   = (c >= BL) && cur_en[d] && !(lz && d > 0 && (cur_v >> (4*d)) == 0);
        e_an  = lit ? ~(8'h01 << d) : 8'hFF;
        e_dpn = lit ? ~cur_dp[d] : 1'b1;
    endfunction

    // Monitor: outputs seen after edge k reflect scan time k.
    int         mk;
    load_t      ld;
    logic       e_ack;
    logic [7:0] e_an;
    logic       e_dpn;
    logic [3:0] e_nib;
    always @(negedge clk) begin
        if (rst_n && npos >= 1) begin
            mk = npos - 1;
            if (mk % F == 0) begin
                while (lq.size() > 0 && lq[0].frame <= mk / F) begin
                    ld = lq.pop_front();
                    cur_v = ld.v; cur_dp = ld.dp; cur_en = ld.en;
                end
            end
            e_ack = 1'b0;
            if (ackq.size() > 0 && ackq[0] == mk) begin
                e_ack = 1'b1;
                void'(ackq.pop_front());
            end
            model(mk, 1'b1, e_an, e_dpn, e_nib);
            chk("an_lz1", mk, 32'(an1), 32'(e_an));
            chk("dpn_lz1", mk, 32'(dpn1), 32'(e_dpn));
            chk("nib_lz1", mk, 32'(nib1), 32'(e_nib));
            model(mk, 1'b0, e_an, e_dpn, e_nib);
            chk("an_lz0", mk, 32'(an0), 32'(e_an));
            chk("dpn_lz0", mk, 32'(dpn0), 32'(e_dpn));
            chk("nib_lz0", mk, 32'(nib0), 32'(e_nib));
            chk("ack_lz1", mk, 32'(ack1), 32'(e_ack));
            chk("ack_lz0", mk, 32'(ack0), 32'(e_ack));
            chk("fs_lz1", mk, 32'(fs1), 32'(mk % F == 0));
            chk("fs_lz0", mk, 32'(fs0), 32'(mk % F == 0));
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        lq.delete();
        ackq.delete();
        cur_v = '0; cur_dp = '0; cur_en = '1;
        #1;
        chk("rst_an_lz1", -1, 32'(an1), 32'hFF);
        chk("rst_an_lz0", -1, 32'(an0), 32'hFF);
        chk("rst_dpn", -1, 32'({dpn1, dpn0}), 32'h3);
        chk("rst_ack", -1, 32'({ack1, ack0}), 32'h0);
        chk("rst_nib", -1, 32'({nib1, nib0}), 32'h0);
        chk("rst_fs", -1, 32'({fs1, fs0}), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Caller is positioned at a negedge; the load is sampled at scan time npos.
    task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en);
        int t;
        int fr;
        t  = npos;
        fr = (t + 1) / F + 1;
        value = v; dp_in = dp; digit_en = en; load = 1'b1;
        if (lq.size() > 0 && lq[lq.size()-1].frame == fr) begin
            lq[lq.size()-1] = '{fr, v, dp, en};
        end else begin
            lq.push_back('{fr, v, dp, en});
            ackq.push_back(fr * F - 1);
        end
        @(negedge clk);
        load = 1'b0;
        value = $urandom; dp_in = 8'($urandom); digit_en = 8'($urandom);
    endtask

    task automatic wait_phase(input int ph);
        @(negedge clk);
        while (npos % F != ph) @(negedge clk);
    endtask

    task automatic run_frames(input int n);
        repeat (n * F) @(negedge clk);
    endtask

    initial begin
        #2;
        do_reset();
        run_frames(2);

        wait_phase(20);
        do_load(32'h1234ABCD, 8'h00, 8'hFF);
        run_frames(2);

        wait_phase(30);
        do_load(32'h000000F0, 8'h01, 8'hFF);
        run_frames(2);

        wait_phase(5);
        do_load(32'h11111111, 8'h00, 8'hFF);
        repeat (7) @(negedge clk);
        do_load(32'h22222222, 8'h00, 8'hFF);
        run_frames(2);

        wait_phase(10);
        do_load(32'hAAAAAAAA, 8'h00, 8'hFF);
        wait_phase(F - 1);
        do_load(32'h55555555, 8'h00, 8'hFF);
        run_frames(3);

        for (int i = 0; i < 25; i++) begin
            logic [31:0] v;
            int nz;
            v  = $urandom;
            nz = $urandom_range(0, 8);
            v  = v >> (4 * nz);
            repeat ($urandom_range(1, 100)) @(negedge clk);
            do_load(v, 8'($urandom), (i % 3 == 0) ? 8'hFF : 8'($urandom));
        end
        run_frames(2);

        wait_phase(3);
        do_load(32'h87654321, 8'h20, 8'hFF);
        run_frames(2);
        @(negedge clk);
        while (!(((npos - 1) % F) / T == 5 && (npos - 1) % T == 4)) @(negedge clk);
        #2;
        do_reset();
        run_frames(2);

        chk("ack_drain", -1, 32'(ackq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog k=%0d got=timeout exp=finish", npos);
        $fatal(1, "timeout");
    end

endmodule
